mem_arbiter: RTL

Shares the single-port program/data memory between three requesters: instruction fetch from the control path, load/store from the datapath (MM/MW accesses), and the external program loader. The loader has absolute priority. Fetch and data alternate round-robin when both request. Each access is one registered transaction on the memory port, with a req/ack handshake back to the winner.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the program/data memory arbiter.
// State encoding and grant identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_IF = 2'd0,
    GNT_DM = 2'd1,
    GNT_LD = 2'd2
  } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority / round-robin picker: loader first,
// then fetch and data alternate on a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_v,
  input  logic dm_v,
  input  logic ld_v,
  input  gnt_t rr_last,
  output logic gnt_v,
  output gnt_t gnt_id
);

  logic dm_win;

  // data wins alone, or on a tie when fetch went last
  assign dm_win = dm_v &&
    (!if_v || rr_last == GNT_IF);

  always_comb begin
    gnt_v  = if_v | dm_v | ld_v;
    gnt_id = GNT_IF;
    unique case (1'b1)
      ld_v:            gnt_id = GNT_LD;
      !ld_v && dm_win: gnt_id = GNT_DM;
      default:         gnt_id = GNT_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch, data and loader
// with one registered access per three cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 16
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_ack,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q, state_d;
  gnt_t          gnt_q, rr_q, pick_id;
  logic          pick_v, grant, we_q;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // a port whose ack is up this cycle is not re-served
  mem_arb_pick u_pick (
    .if_v    (if_req & ~if_ack),
    .dm_v    (dm_req & ~dm_ack),
    .ld_v    (ld_req & ~ld_ack),
    .rr_last (rr_q),
    .gnt_v   (pick_v),
    .gnt_id  (pick_id)
  );

  assign grant = (state_q == IDLE) && pick_v;
  assign busy  = (state_q != IDLE);

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = if_addr;
    sel_wdata = '0;
    unique case (pick_id)
      GNT_DM: begin
        sel_we    = dm_we;
        sel_addr  = dm_addr;
        sel_wdata = dm_wdata;
      end
      GNT_LD: begin
        sel_we    = ld_we;
        sel_addr  = ld_addr;
        sel_wdata = ld_wdata;
      end
      default: begin
        sel_we    = 1'b0;
        sel_addr  = if_addr;
        sel_wdata = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_v) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_IF;
      rr_q      <= GNT_DM;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      ld_ack    <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_en  <= grant;
      mem_we  <= grant & sel_we;
      if (grant) begin
        gnt_q     <= pick_id;
        we_q      <= sel_we;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        if (pick_id != GNT_LD)
          rr_q <= pick_id;
      end
      if_ack <= (state_q == WAIT) && (gnt_q == GNT_IF);
      dm_ack <= (state_q == WAIT) && (gnt_q == GNT_DM);
      ld_ack <= (state_q == WAIT) && (gnt_q == GNT_LD);
      if ((state_q == WAIT) && !we_q)
        rdata <= mem_rdata;
    end
  end

endmodule
